// File: rtl/ir_grid_scanner_pkg.sv
// Shared definitions for the IR break-beam grid scanner and the VGA box logic that consumes ir_out.
package ir_grid_pkg;

    localparam int GRID_ROWS  = 5;
    localparam int GRID_COLS  = 5;
    localparam int GRID_CELLS = GRID_ROWS * GRID_COLS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } scan_state_t;

    function automatic int idx(input int r, input int c);
        return r * GRID_COLS + c;
    endfunction

    // Active-low one-hot row drive for row r.
    function automatic logic [GRID_ROWS-1:0] row_drive_n(input logic [2:0] r);
        return ~(GRID_ROWS'(1) << r);
    endfunction

endpackage

// File: rtl/ir_grid_scanner_debounce.sv
// Per-cell debouncer: the held state flips only after DEBOUNCE_CNT consecutive disagreeing samples.
module ir_cell_debounce #(
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic clk,
    input  logic resetn,
    input  logic sample_en,
    input  logic sample_n,
    output logic state,
    output logic state_next
);

    logic [2:0] count;
    logic [2:0] count_next;

    always_comb begin
        state_next = state;
        count_next = count;
        if (sample_en) begin
            if (sample_n == state) begin
                count_next = '0;
            end else if ((count + 3'd1) == 3'(DEBOUNCE_CNT)) begin
                state_next = ~state;
                count_next = '0;
            end else begin
                count_next = count + 3'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= 1'b1;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

endmodule

// File: rtl/ir_grid_scanner.sv
// Row-scanning 5x5 IR break-beam reader with per-cell debounce and frame-coherent active-low output.
// Optional sticky trace of broken beams when TRACE_LATCH_EN is defined.
module ir_grid_scanner
    import ir_grid_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int DEBOUNCE_CNT  = 3
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  scan_en,
    input  logic                  clear,
    input  logic [GRID_COLS-1:0]  col_sense_n,
    output logic [GRID_ROWS-1:0]  row_sel_n,
    output logic [GRID_CELLS-1:0] ir_out,
    output logic                  frame_done
);

    localparam int          SW          = $clog2(SETTLE_CYCLES + 1);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]  LAST_ROW    = 3'(GRID_ROWS - 1);

    scan_state_t           state;
    logic [2:0]            row;
    logic [SW-1:0]         settle_cnt;
    logic [GRID_COLS-1:0]  col_meta;
    logic [GRID_COLS-1:0]  col_sync;
    logic [GRID_ROWS-1:0]  sample_row;
    logic [GRID_CELLS-1:0] deb_state;
    logic [GRID_CELLS-1:0] deb_next;
    logic [GRID_CELLS-1:0] publish;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_sense_n;
            col_sync <= col_meta;
        end
    end

    always_comb begin
        sample_row = '0;
        if (state == SAMPLE) begin
            sample_row[row] = 1'b1;
        end
    end

    for (genvar r = 0; r < GRID_ROWS; r++) begin : g_row
        for (genvar c = 0; c < GRID_COLS; c++) begin : g_col
            ir_cell_debounce #(
                .DEBOUNCE_CNT(DEBOUNCE_CNT)
            ) u_cell (
                .clk        (clk),
                .resetn     (resetn),
                .sample_en  (sample_row[r]),
                .sample_n   (col_sync[c]),
                .state      (deb_state[idx(r, c)]),
                .state_next (deb_next[idx(r, c)])
            );
        end
    end

`ifdef TRACE_LATCH_EN
    logic [GRID_CELLS-1:0] trace;
    logic [GRID_CELLS-1:0] trace_base;

    // clear wins over the old contents, but cells that are low right now re-set at once.
    assign trace_base = clear ? '0 : trace;
    assign publish    = ~(trace_base | ~deb_next);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            trace <= '0;
        end else begin
            trace <= trace_base | ~deb_state;
        end
    end
`else
    logic unused_inputs;
    assign unused_inputs = clear ^ (^deb_state);
    assign publish       = deb_next;
`endif

    // The last row's sample lands on the same edge that publishes, hence deb_next above.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            row        <= '0;
            settle_cnt <= '0;
            row_sel_n  <= '1;
            frame_done <= 1'b0;
            ir_out     <= '1;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_en) begin
                        state      <= DRIVE;
                        row        <= '0;
                        settle_cnt <= '0;
                        row_sel_n  <= row_drive_n(3'd0);
                    end
                end
                DRIVE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                SAMPLE: begin
                    if (row == LAST_ROW) begin
                        state      <= DONE;
                        row_sel_n  <= '1;
                        frame_done <= 1'b1;
                        ir_out     <= publish;
                    end else begin
                        state      <= DRIVE;
                        row        <= row + 3'd1;
                        settle_cnt <= '0;
                        row_sel_n  <= row_drive_n(row + 3'd1);
                    end
                end
                DONE: begin
                    if (scan_en) begin
                        state      <= DRIVE;
                        row        <= '0;
                        settle_cnt <= '0;
                        row_sel_n  <= row_drive_n(3'd0);
                    end else begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ir_grid_scanner.sv
// Bench for ir_grid_scanner: sensor-matrix model, directed scenarios and a randomized frame-level reference.
module tb_ir_grid_scanner;

    localparam int FRAME_CLKS = 26;
    localparam int DEB        = 3;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        scan_en = 1'b0;
    logic        clear = 1'b0;
    logic [4:0]  col_sense_n;
    logic [4:0]  row_sel_n;
    logic [24:0] ir_out;
    logic        frame_done;

    logic [24:0] grid_n = '1;

    int total = 0;
    int bad   = 0;

    logic [24:0] m_state;
    int          m_cnt [25];
    logic [24:0] m_trace;

    ir_grid_scanner dut (
        .clk         (clk),
        .resetn      (resetn),
        .scan_en     (scan_en),
        .clear       (clear),
        .col_sense_n (col_sense_n),
        .row_sel_n   (row_sel_n),
        .ir_out      (ir_out),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Physical matrix: a driven row pulls a column low wherever its beam is broken.
    always_comb begin
        col_sense_n = '1;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (!row_sel_n[r] && !grid_n[r*5+c]) col_sense_n[c] = 1'b0;
            end
        end
    end

    function automatic void model_reset();
        m_state = '1;
        m_trace = '0;
        for (int i = 0; i < 25; i++) m_cnt[i] = 0;
    endfunction

    // One whole frame: every cell sees exactly one sample of the pattern.
    function automatic void model_frame(input logic [24:0] pat);
        for (int i = 0; i < 25; i++) begin
            if (pat[i] == m_state[i]) begin
                m_cnt[i] = 0;
            end else begin
                m_cnt[i] = m_cnt[i] + 1;
                if (m_cnt[i] >= DEB) begin
                    m_state[i] = pat[i];
                    m_cnt[i]   = 0;
                end
            end
        end
        m_trace = m_trace | ~m_state;
    endfunction

    function automatic void model_clear();
        m_trace = ~m_state;
    endfunction

    function automatic logic [24:0] model_out();
`ifdef TRACE_LATCH_EN
        return ~m_trace;
`else
        return m_state;
`endif
    endfunction

    task automatic do_reset(input logic en);
        @(negedge clk);
        resetn  = 1'b0;
        scan_en = 1'b0;
        clear   = 1'b0;
        grid_n  = '1;
        repeat (2) @(negedge clk);
        model_reset();
        scan_en = en;
        resetn  = 1'b1;
    endtask

    task automatic wait_frame(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!frame_done && cycles < 200);
        if (!frame_done) begin
            total++;
            bad++;
            $display("[TB] FAIL frame_timeout waited=%0d cycles, frame_done never pulsed", cycles);
        end
    endtask

    task automatic wait_row(input logic [4:0] target);
        int n;
        n = 0;
        while (row_sel_n !== target && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (row_sel_n !== target) begin
            total++;
            bad++;
            $display("[TB] FAIL row_timeout got=%b want=%b", row_sel_n, target);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (row_sel_n !== 5'h1F) begin bad++; $display("[TB] FAIL reset_row got=%b want=11111", row_sel_n); end
        total++;
        if (ir_out !== 25'h1FFFFFF) begin bad++; $display("[TB] FAIL reset_ir got=%h want=1ffffff", ir_out); end
        total++;
        if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_done got=%b want=0", frame_done); end
    endtask

    task automatic test_first_frame();
        logic [4:0] exp_row;
        do_reset(1'b1);
        for (int r = 0; r < 5; r++) begin
            exp_row = ~(5'b00001 << r);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                total++;
                if (row_sel_n !== exp_row || frame_done !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL scan_row r=%0d k=%0d got=%b/%b want=%b/0", r, k, row_sel_n, frame_done, exp_row);
                end
            end
        end
        @(negedge clk);
        total++;
        if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL first_done got=%b want=1 at clock 26", frame_done); end
        total++;
        if (ir_out !== 25'h1FFFFFF) begin bad++; $display("[TB] FAIL first_ir got=%h want=1ffffff", ir_out); end
        total++;
        if (row_sel_n !== 5'h1F) begin bad++; $display("[TB] FAIL done_row got=%b want=11111", row_sel_n); end
    endtask

    task automatic test_debounce_flip();
        int cyc;
        logic [24:0] exp;
        do_reset(1'b1);
        grid_n[7] = 1'b0;
        for (int f = 1; f <= 3; f++) begin
            wait_frame(cyc);
            exp = (f == 3) ? 25'h1FFFF7F : 25'h1FFFFFF;
            total++;
            if (ir_out !== exp) begin bad++; $display("[TB] FAIL flip_frame%0d got=%h want=%h", f, ir_out, exp); end
        end
    endtask

    task automatic test_glitch();
        int cyc;
        do_reset(1'b1);
        grid_n[12] = 1'b0;
        for (int f = 1; f <= 5; f++) begin
            wait_frame(cyc);
            total++;
            if (ir_out !== 25'h1FFFFFF) begin bad++; $display("[TB] FAIL glitch_frame%0d got=%h want=1ffffff", f, ir_out); end
            if (f == 2) grid_n = '1;
        end
    endtask

    task automatic test_scan_stop();
        int  pulses;
        bit  saw3;
        bit  saw4;
        do_reset(1'b1);
        wait_row(5'b11011);
        scan_en = 1'b0;
        pulses = 0;
        saw3 = 1'b0;
        saw4 = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (row_sel_n === 5'b10111) saw3 = 1'b1;
            if (row_sel_n === 5'b01111) saw4 = 1'b1;
            if (frame_done === 1'b1) pulses++;
        end
        total++;
        if (!saw3 || !saw4) begin bad++; $display("[TB] FAIL stop_rows got row3=%0d row4=%0d want both 1", saw3, saw4); end
        total++;
        if (pulses != 1) begin bad++; $display("[TB] FAIL stop_pulses got=%0d want=1", pulses); end
        total++;
        if (row_sel_n !== 5'h1F) begin bad++; $display("[TB] FAIL stop_idle got=%b want=11111", row_sel_n); end
    endtask

    task automatic test_reset_midrow();
        do_reset(1'b1);
        grid_n = 25'h0;
        wait_row(5'b11011);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        total++;
        if (row_sel_n !== 5'h1F) begin bad++; $display("[TB] FAIL async_row got=%b want=11111", row_sel_n); end
        total++;
        if (ir_out !== 25'h1FFFFFF || frame_done !== 1'b0) begin
            bad++;
            $display("[TB] FAIL async_out got=%h/%b want=1ffffff/0", ir_out, frame_done);
        end
        @(negedge clk);
        grid_n = '1;
        resetn = 1'b1;
        @(negedge clk);
        total++;
        if (row_sel_n !== 5'b11110) begin bad++; $display("[TB] FAIL restart_row got=%b want=11110", row_sel_n); end
    endtask

    task automatic test_cell_recovery();
        int cyc;
        logic exp_bit0;
        do_reset(1'b1);
        for (int f = 1; f <= 8; f++) begin
            grid_n = (f <= 3) ? 25'h1FFFFFE : 25'h1FFFFFF;
            wait_frame(cyc);
            model_frame(grid_n);
            total++;
            if (ir_out !== model_out()) begin bad++; $display("[TB] FAIL recov_frame%0d got=%h want=%h", f, ir_out, model_out()); end
        end
`ifdef TRACE_LATCH_EN
        exp_bit0 = 1'b0;
`else
        exp_bit0 = 1'b1;
`endif
        total++;
        if (ir_out[0] !== exp_bit0) begin bad++; $display("[TB] FAIL recov_bit0 got=%b want=%b", ir_out[0], exp_bit0); end
        clear = 1'b1;
        model_clear();
        @(negedge clk);
        clear = 1'b0;
        wait_frame(cyc);
        model_frame(grid_n);
        total++;
        if (ir_out !== 25'h1FFFFFF) begin bad++; $display("[TB] FAIL clear_frame got=%h want=1ffffff", ir_out); end
    endtask

    task automatic test_random();
        int          cyc;
        logic [24:0] cur;
        do_reset(1'b1);
        cur = '1;
        for (int f = 0; f < 40; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                cur = '1;
                for (int k = 0; k < int'($urandom_range(1, 3)); k++) cur[$urandom_range(0, 24)] = 1'b0;
            end
            grid_n = cur;
            wait_frame(cyc);
            model_frame(grid_n);
            total++;
            if (ir_out !== model_out()) begin bad++; $display("[TB] FAIL rand_ir f=%0d got=%h want=%h", f, ir_out, model_out()); end
            total++;
            if (cyc != FRAME_CLKS) begin bad++; $display("[TB] FAIL rand_period f=%0d got=%0d want=%0d", f, cyc, FRAME_CLKS); end
            if ($urandom_range(0, 5) == 0) begin
                clear = 1'b1;
                model_clear();
                @(negedge clk);
                clear = 1'b0;
                grid_n = cur;
                wait_frame(cyc);
                model_frame(grid_n);
                total++;
                if (ir_out !== model_out()) begin bad++; $display("[TB] FAIL rand_clear f=%0d got=%h want=%h", f, ir_out, model_out()); end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_first_frame();
        test_debounce_flip();
        test_glitch();
        test_scan_stop();
        test_reset_midrow();
        test_cell_recovery();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
